// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb
//
// IF-stage branch prediction unit. A direct-mapped branch target buffer holds
// one entry per index. Each entry has a valid bit, a tag, a target and a
// 2-bit history counter. A fetch PC is looked up combinationally, with zero
// latency. Branches resolved in EX train the table and raise a mispredict and
// redirect request. The unit also keeps saturating branch and mispredict
// statistics.
//
// Parameters
//   ADDR_W  : PC / target width
//   ENTRIES : BTB entries (power of two, >= 2)
//   MODE    : 0 static not-taken, 1 two-bit bimodal, 2 one-bit last outcome
//   CNT_W   : statistics counter width
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-high reset
//   fetch_pc         in   PC fetched this cycle
//   pred_taken       out  fetch_pc predicted taken (combinational)
//   pred_target      out  predicted next PC (combinational)
//   upd_valid        in   a branch resolved in EX this cycle
//   upd_pc           in   PC of the resolved branch
//   upd_taken        in   actual outcome
//   upd_target       in   actual taken target
//   upd_pred_taken   in   prediction made for that branch
//   upd_pred_target  in   target predicted for that branch
//   flush            in   synchronous invalidate of all entries
//   mispredict       out  resolved branch was mispredicted (combinational)
//   redirect_pc      out  correct next PC for the resolved branch
//   br_count         out  resolved-branch count, saturating
//   mp_count         out  mispredict count, saturating
// -----------------------------------------------------------------------------
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int MODE    = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              flush,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Table storage
    logic              r_valid  [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];

    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_mp_count;

    // Lookup side
    logic [IDX_W-1:0]  w_fetch_idx;
    logic [TAG_W-1:0]  w_fetch_tag;
    logic              w_fetch_hit;
    logic [1:0]        w_fetch_ctr;
    logic              w_pred_taken;

    // Update side
    logic [IDX_W-1:0]  w_upd_idx;
    logic [TAG_W-1:0]  w_upd_tag;
    logic              w_upd_hit;
    logic [1:0]        w_upd_ctr;
    logic [1:0]        w_ctr_next;
    logic              w_tbl_en;
    logic              w_mispredict;
    logic              w_unused;

    // -------------------------------------------------------------------------
    // Lookup
    // -------------------------------------------------------------------------
    assign w_fetch_idx = fetch_pc[IDX_W+1:2];
    assign w_fetch_tag = fetch_pc[ADDR_W-1:IDX_W+2];
    assign w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign w_fetch_ctr = r_ctr[w_fetch_idx];

    generate
        if (MODE == 1) begin : g_pred_bimodal
            assign w_pred_taken = w_fetch_hit && w_fetch_ctr[1];
        end else if (MODE == 2) begin : g_pred_last
            assign w_pred_taken = w_fetch_hit && w_fetch_ctr[0];
        end else begin : g_pred_static
            assign w_pred_taken = 1'b0;
        end
    endgenerate

    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_taken ? r_target[w_fetch_idx] : fetch_pc + ADDR_W'(4);

    // -------------------------------------------------------------------------
    // Resolution
    // -------------------------------------------------------------------------
    // A taken branch is also wrong when it was predicted taken to the wrong place.
    assign w_mispredict = upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));
    assign mispredict   = w_mispredict;
    assign redirect_pc  = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

    // -------------------------------------------------------------------------
    // Training
    // -------------------------------------------------------------------------
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_ctr = r_ctr[w_upd_idx];
    // A static predictor never writes its table; flush overrides any training.
    assign w_tbl_en  = upd_valid && (MODE != 0) && !flush;

    // Next counter value for the indexed entry. A miss on a taken branch is
    // an allocation and gets the mode's initial "taken" value.
    always_comb begin
        w_ctr_next = w_upd_ctr;
        if (MODE == 1) begin
            if (upd_taken) begin
                if (!w_upd_hit) begin
                    w_ctr_next = 2'b10;
                end else if (w_upd_ctr != 2'b11) begin
                    w_ctr_next = w_upd_ctr + 2'b01;
                end
            end else if (w_upd_ctr != 2'b00) begin
                w_ctr_next = w_upd_ctr - 2'b01;
            end
        end else if (MODE == 2) begin
            w_ctr_next = upd_taken ? 2'b01 : 2'b00;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Valid and counter state are reset; flush clears valid only.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_ctr[gi]   <= 2'b01;
                end else if (flush) begin
                    r_valid[gi] <= 1'b0;
                end else if (w_tbl_en && (w_upd_idx == IDX_W'(gi))) begin
                    if (upd_taken) begin
                        r_valid[gi] <= 1'b1;
                        r_ctr[gi]   <= w_ctr_next;
                    end else if (w_upd_hit) begin
                        // A not-taken miss leaves the table alone.
                        r_ctr[gi]   <= w_ctr_next;
                    end
                end
            end

            // Tag and target are meaningless while the entry is invalid, so they
            // carry no reset. Taken hits and allocations both rewrite them.
            always_ff @(posedge clock) begin
                if (!reset && w_tbl_en && upd_taken && (w_upd_idx == IDX_W'(gi))) begin
                    r_tag[gi]    <= w_upd_tag;
                    r_target[gi] <= upd_target;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Statistics (independent of MODE and flush)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else if (upd_valid) begin
            if (r_br_count != {CNT_W{1'b1}}) begin
                r_br_count <= r_br_count + CNT_W'(1);
            end
            if (w_mispredict && (r_mp_count != {CNT_W{1'b1}})) begin
                r_mp_count <= r_mp_count + CNT_W'(1);
            end
        end
    end

    assign br_count = r_br_count;
    assign mp_count = r_mp_count;

    // Byte-offset bits and mode-dependent counter bits are intentionally unused.
    assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0], w_fetch_ctr};

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] fetch_pc;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          flush;

    logic d0_pt, d1_pt, d2_pt, d4_pt;
    logic [AW-1:0] d0_tg, d1_tg, d2_tg, d4_tg;
    logic d0_mp, d1_mp, d2_mp, d4_mp;
    logic [AW-1:0] d0_rd, d1_rd, d2_rd, d4_rd;
    logic [15:0] d0_br, d1_br, d2_br, d0_mc, d1_mc, d2_mc;
    logic [3:0]  d4_br, d4_mc;

    int errors;
    int checks;

    always #5 clock = ~clock;

    branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(16), .MODE(0), .CNT_W(16)) d0 (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(d0_pt), .pred_target(d0_tg),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .flush(flush),
        .mispredict(d0_mp), .redirect_pc(d0_rd), .br_count(d0_br), .mp_count(d0_mc));

    branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(16), .MODE(1), .CNT_W(16)) d1 (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(d1_pt), .pred_target(d1_tg),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .flush(flush),
        .mispredict(d1_mp), .redirect_pc(d1_rd), .br_count(d1_br), .mp_count(d1_mc));

    branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(16), .MODE(2), .CNT_W(16)) d2 (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(d2_pt), .pred_target(d2_tg),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .flush(flush),
        .mispredict(d2_mp), .redirect_pc(d2_rd), .br_count(d2_br), .mp_count(d2_mc));

    branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(16), .MODE(1), .CNT_W(4)) d4 (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(d4_pt), .pred_target(d4_tg),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .flush(flush),
        .mispredict(d4_mp), .redirect_pc(d4_rd), .br_count(d4_br), .mp_count(d4_mc));

    // ------------------------------------------------------------------------
    // Behavioural model: per mode, a 16-slot table of remembered branches
    // ------------------------------------------------------------------------
    bit            m_valid [3][16];
    logic [25:0]   m_tag   [3][16];
    logic [AW-1:0] m_tgt   [3][16];
    int            m_ctr   [3][16];
    int            br_n;
    int            mp_n;

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int e = 0; e < 16; e++) begin
                m_valid[m][e] = 1'b0;
                m_ctr[m][e]   = 1;
            end
        end
        br_n = 0;
        mp_n = 0;
    endtask

    function automatic bit exp_mispredict();
        return upd_valid && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    task automatic model_update();
        int idx;
        logic [25:0] tg;
        bit hit;
        idx = int'(upd_pc[5:2]);
        tg  = upd_pc[31:6];
        for (int m = 1; m < 3; m++) begin
            hit = m_valid[m][idx] && (m_tag[m][idx] == tg);
            if (flush) begin
                for (int e = 0; e < 16; e++) m_valid[m][e] = 1'b0;
            end else if (upd_valid) begin
                if (upd_taken) begin
                    if (hit) begin
                        m_ctr[m][idx] = (m == 1) ? ((m_ctr[m][idx] >= 3) ? 3 : m_ctr[m][idx] + 1) : 1;
                    end else begin
                        m_valid[m][idx] = 1'b1;
                        m_tag[m][idx]   = tg;
                        m_ctr[m][idx]   = (m == 1) ? 2 : 1;
                    end
                    m_tgt[m][idx] = upd_target;
                end else if (hit) begin
                    m_ctr[m][idx] = (m == 1) ? ((m_ctr[m][idx] <= 0) ? 0 : m_ctr[m][idx] - 1) : 0;
                end
            end
        end
        if (upd_valid) begin
            br_n = br_n + 1;
            if (exp_mispredict()) mp_n = mp_n + 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int m, input string nm, input logic pt, input logic [AW-1:0] tg,
                              input logic mpo, input logic [AW-1:0] rd,
                              input logic [63:0] br, input logic [63:0] mc, input int cntw);
        int idx;
        bit hit;
        bit ept;
        logic [AW-1:0] etg;
        logic [63:0] sat;
        idx = int'(fetch_pc[5:2]);
        hit = m_valid[m][idx] && (m_tag[m][idx] == fetch_pc[31:6]);
        if (m == 1)      ept = hit && (m_ctr[m][idx] >= 2);
        else if (m == 2) ept = hit && ((m_ctr[m][idx] % 2) == 1);
        else             ept = 1'b0;
        etg = ept ? m_tgt[m][idx] : fetch_pc + 32'd4;
        sat = (64'd1 << cntw) - 64'd1;
        chk({nm, ".pred_taken"}, 64'(pt), 64'(ept));
        chk({nm, ".pred_target"}, 64'(tg), 64'(etg));
        chk({nm, ".mispredict"}, 64'(mpo), 64'(exp_mispredict()));
        if (upd_valid) chk({nm, ".redirect_pc"}, 64'(rd), 64'(upd_taken ? upd_target : upd_pc + 32'd4));
        chk({nm, ".br_count"}, br, (64'(br_n) > sat) ? sat : 64'(br_n));
        chk({nm, ".mp_count"}, mc, (64'(mp_n) > sat) ? sat : 64'(mp_n));
    endtask

    task automatic compare_all();
        check_inst(0, "m0", d0_pt, d0_tg, d0_mp, d0_rd, 64'(d0_br), 64'(d0_mc), 16);
        check_inst(1, "m1", d1_pt, d1_tg, d1_mp, d1_rd, 64'(d1_br), 64'(d1_mc), 16);
        check_inst(2, "m2", d2_pt, d2_tg, d2_mp, d2_rd, 64'(d2_br), 64'(d2_mc), 16);
        check_inst(1, "c4", d4_pt, d4_tg, d4_mp, d4_rd, 64'(d4_br), 64'(d4_mc), 4);
    endtask

    // Called with inputs settled between edges: check, clock, advance model.
    task automatic cycle();
        compare_all();
        @(posedge clock);
        if (upd_valid)
            $display("txn pc=%08h taken=%0b tgt=%08h flush=%0b exp_mp=%0b", upd_pc, upd_taken,
                     upd_target, flush, exp_mispredict());
        if (reset) model_reset();
        else       model_update();
        @(negedge clock);
    endtask

    task automatic set_idle(input logic [AW-1:0] pc);
        fetch_pc  = pc;
        upd_valid = 1'b0;
        flush     = 1'b0;
        #1;
    endtask

    task automatic set_upd(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt,
                           input logic pt, input logic [AW-1:0] ptg, input logic fl);
        fetch_pc        = pc;
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptg;
        flush           = fl;
        #1;
    endtask

    function automatic logic [AW-1:0] rand_pc();
        logic [AW-1:0] p;
        p = $urandom();
        if ($urandom_range(0, 7) != 0) p[31:6] = 26'($urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        bit exp1 [5];
        bit exp2 [5];
        bit nt   [4];
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        set_idle(32'h40);
        model_reset();
        reset = 1'b1;
        @(negedge clock);
        set_idle(32'h40);
        cycle();
        reset = 1'b0;

        // Step 1: reset state
        set_idle(32'h40);
        chk("s1.pred_taken", 64'(d1_pt), 64'd0);
        chk("s1.pred_target", 64'(d1_tg), 64'h44);
        chk("s1.br_count", 64'(d1_br), 64'd0);
        chk("s1.mp_count", 64'(d1_mc), 64'd0);
        cycle();

        // Step 2: first taken branch allocates
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("s2.mispredict", 64'(d1_mp), 64'd1);
        chk("s2.redirect_pc", 64'(d1_rd), 64'h100);
        cycle();
        set_idle(32'h40);
        chk("s2.pred_taken", 64'(d1_pt), 64'd1);
        chk("s2.pred_target", 64'(d1_tg), 64'h100);
        chk("s2.br_count", 64'(d1_br), 64'd1);
        chk("s2.mp_count", 64'(d1_mc), 64'd1);
        cycle();

        // Step 3: counter walk NT,NT,T,T; first entry pins pre-edge lookup
        exp1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        nt   = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_upd(32'h40, nt[k], 32'h100, nt[k], 32'h100, 1'b0);
            else       set_idle(32'h40);
            chk($sformatf("s3.m1.pred%0d", k), 64'(d1_pt), 64'(exp1[k]));
            chk($sformatf("s3.m2.pred%0d", k), 64'(d2_pt), 64'(exp2[k]));
            cycle();
        end

        // Step 4: aliasing at index 0
        set_idle(32'h80);
        chk("s4.alias_miss", 64'(d1_pt), 64'd0);
        chk("s4.alias_tgt", 64'(d1_tg), 64'h84);
        cycle();
        set_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        cycle();
        set_idle(32'h80);
        chk("s4.new_hit", 64'(d1_pt), 64'd1);
        chk("s4.new_tgt", 64'(d1_tg), 64'h200);
        cycle();
        set_idle(32'h40);
        chk("s4.evicted", 64'(d1_pt), 64'd0);
        cycle();

        // Step 5: flush beats allocation, stats still count
        set_upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        cycle();
        set_idle(32'h40);
        chk("s5.flush_40", 64'(d1_pt), 64'd0);
        chk("s5.flush_40_m2", 64'(d2_pt), 64'd0);
        chk("s5.br_count", 64'(d1_br), 64'd7);
        chk("s5.mp_count", 64'(d1_mc), 64'd3);
        cycle();
        set_idle(32'h80);
        chk("s5.flush_80", 64'(d1_pt), 64'd0);
        cycle();

        // Asynchronous reset between edges
        set_upd(32'h40, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
        cycle();
        set_idle(32'h40);
        chk("s5.pre_rst_hit", 64'(d1_pt), 64'd1);
        cycle();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst.pred_taken", 64'(d1_pt), 64'd0);
        chk("rst.pred_target", 64'(d1_tg), 64'h44);
        chk("rst.mispredict", 64'(d1_mp), 64'd0);
        chk("rst.br_count", 64'(d1_br), 64'd0);
        chk("rst.mp_count", 64'(d1_mc), 64'd0);
        model_reset();
        @(negedge clock);
        set_idle(32'h40);
        cycle();
        reset = 1'b0;

        // Step 6: 20 mispredicting updates saturate the narrow counters
        for (int k = 0; k < 20; k++) begin
            set_upd(32'h40, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
            cycle();
        end
        set_idle(32'h40);
        chk("s6.c4_br", 64'(d4_br), 64'd15);
        chk("s6.c4_mp", 64'(d4_mc), 64'd15);
        chk("s6.m1_br", 64'(d1_br), 64'd20);
        chk("s6.m1_mp", 64'(d1_mc), 64'd20);
        chk("s6.m0_pred", 64'(d0_pt), 64'd0);
        chk("s6.m1_pred", 64'(d1_pt), 64'd1);
        cycle();

        // Randomised phase against the model
        for (int k = 0; k < 600; k++) begin
            logic [AW-1:0] pc;
            logic [AW-1:0] tgt;
            pc  = rand_pc();
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                set_upd(pc, 1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) != 0) ? tgt : 32'($urandom()),
                        ($urandom_range(0, 19) == 0));
                if ($urandom_range(0, 1) != 0) begin
                    fetch_pc = rand_pc();
                    #1;
                end
            end else begin
                set_idle(pc);
                flush = ($urandom_range(0, 19) == 0);
                #1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch prediction unit for the IF stage of the 5-stage pipelined CPU. It replaces fixed-target redirect with a direct-mapped branch target buffer (BTB) plus per-entry history counters.
- It gives a same-cycle prediction for the fetch PC.
- It resolves branches reported from EX and raises a mispredict/redirect to the PC logic.
- It keeps saturating branch and mispredict statistics.

Parameters:
ADDR_W, 32, PC/target width in bits.
ENTRIES, 16, number of BTB entries; power of two, >= 2. IDX_W = log2(ENTRIES).
MODE, 1, 0 = static not-taken (table never written), 1 = 2-bit bimodal, 2 = 1-bit last-outcome.
CNT_W, 16, width of the statistics counters.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
fetch_pc  in  ADDR_W  PC being fetched this cycle.
pred_taken  out  1  combinational: fetch_pc predicted taken.
pred_target  out  ADDR_W  combinational: next-PC prediction.
upd_valid  in  1  a branch resolved in EX this cycle.
upd_pc  in  ADDR_W  PC of the resolved branch.
upd_taken  in  1  actual branch outcome.
upd_target  in  ADDR_W  actual taken target.
upd_pred_taken  in  1  prediction that was made for this branch (carried down the pipe).
upd_pred_target  in  ADDR_W  target that was predicted.
flush  in  1  synchronous invalidate of all BTB entries.
mispredict  out  1  combinational: resolved branch was mispredicted.
redirect_pc  out  ADDR_W  combinational: correct next PC. Equals upd_target if upd_taken, else upd_pc+4.
br_count  out  CNT_W  resolved-branch count, saturating.
mp_count  out  CNT_W  mispredict count, saturating.

Behaviour:

Address fields and entries:
- index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Each entry holds valid, tag, target and a 2-bit ctr.

Reset (asynchronous, any time, including mid-update):
- All valid bits = 0; all ctr = 2'b01.
- br_count = mp_count = 0.
- Outputs then read pred_taken=0, pred_target=fetch_pc+4, mispredict=0 with upd_valid=0.

Lookup (combinational, zero latency):
- hit = valid[index] && tag match.
- pred_taken by mode:
  - MODE 0: always 0.
  - MODE 1: hit && ctr[1].
  - MODE 2: hit && ctr[0].
- pred_target = entry target if pred_taken, else fetch_pc+4. All adds wrap modulo 2^ADDR_W.

Mispredict (combinational):
- mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
- When upd_valid=0, redirect_pc is don't-care.

Update (rising edge, upd_valid=1, MODE != 0; uses table state from before the edge):
- Taken, hit: target is rewritten. MODE 1: ctr saturating-increments (11 holds). MODE 2: ctr = 01.
- Taken, miss: allocate and overwrite the indexed entry (evicts any alias). valid=1, new tag, target. ctr = 10 in MODE 1, 01 in MODE 2.
- Not taken, hit: MODE 1: ctr saturating-decrements (00 holds). MODE 2: ctr = 00. Entry stays valid.
- Not taken, miss: no table change.

Statistics (every upd_valid, all modes):
- br_count += 1; mp_count += 1 if mispredict.
- Both saturate at 2^CNT_W-1.
- flush does not clear them.

Flush:
- At the edge, clears all valid bits; ctr and target are untouched.
- flush and upd_valid in the same cycle: flush wins for the table (no allocation/counter change); statistics still update.

Same-cycle ordering:
- Lookup and update to the same index in one cycle: lookup returns pre-edge contents (no bypass). The new state is visible from the next cycle.

Test Plan:
1. ENTRIES=16, MODE=1, after reset: fetch_pc=0x40 -> pred_taken=0, pred_target=0x44; br_count=mp_count=0.
2. upd pc=0x40 taken target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle fetch_pc=0x40 -> pred_taken=1, pred_target=0x100; br_count=1, mp_count=1.
3. Counter walk on 0x40 after step 2 (ctr=10), outcomes NT,NT,T,T:
   - ctr sequence 01, 00, 01, 10.
   - pred_taken after each update: 0, 0, 0, 1.
   - Repeat in MODE 2: pred_taken 0, 0, 1, 1.
4. Aliasing: 0x40 allocated, then fetch_pc=0x80 (same index 0, different tag) -> miss, pred_target=0x84. Taken upd 0x80 target 0x200 evicts it: 0x80 hits, 0x40 misses.
5. flush=1 with taken upd 0x40 in the same cycle -> no entry valid afterwards; br_count still increments. Assert reset mid-sequence -> all outputs return to reset values immediately, without waiting for a clock.
6. CNT_W=4: 20 consecutive mispredicting updates -> mp_count=15, br_count=15 held. MODE 0: taken updates never change pred_taken (stays 0).
